adrv9001_rx_cal: RTL and testbench
==================================

Name: adrv9001_rx_cal

Overview:
Delay-calibration sequencer for the ADRV9001 RX LVDS capture path. It sweeps the shared input-delay tap across its full range and, at each tap, checks the captured AXIS words against a known test pattern sent by the transceiver. It finds the longest contiguous run of passing taps and loads the centre tap. It sits beside the RX capture block on its clk domain, monitors its m_axis output, and drives its runtime delay-load interface.

Parameters:
TAP_WIDTH, 5, delay tap width; taps 0..2^TAP_WIDTH-1 (MAX_TAP=31)
DATA_WIDTH, 32, monitored AXIS word width
SETTLE_CYCLES, 64, clk cycles ignored after each tap load
CHECK_SAMPLES, 256, valid beats compared per tap
TIMEOUT_CYCLES, 4096, max clk cycles in CHECK before the tap is declared failed

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
start  in  1  begin calibration; sampled only in IDLE
pattern  in  DATA_WIDTH  expected word, held static during a run
mon_tvalid  in  1  valid of the monitored RX AXIS stream (passive tap, no tready)
mon_tdata  in  DATA_WIDTH  data of the monitored RX AXIS stream
dly_tap  out  TAP_WIDTH  delay value presented to the RX capture block
dly_load  out  1  one-cycle strobe; capture block latches dly_tap on it
busy  out  1  high from LOAD of tap 0 through APPLY
done  out  1  one-cycle pulse at end of run
pass  out  1  1 if at least one tap passed; held until next start
best_tap  out  TAP_WIDTH  selected centre tap; held
eye_width  out  TAP_WIDTH+1  length of the longest passing run (0..32); held

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: dly_tap=0, dly_load=0, busy=0, done=0, pass=0, best_tap=0, eye_width=0, state=IDLE.
- rst wins over start. rst during a run aborts it on the next edge, with no further dly_load.
- IDLE: on start=1, clear tap, cur_len, best_len, best_start, pass, best_tap and eye_width. Go to LOAD on the next cycle.
- start while busy is ignored.
- LOAD (1 cycle): dly_tap<=tap, dly_load=1. Go to SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. mon_* are ignored. Then go to CHECK with sample_cnt=0, err=0, to_cnt=0.
- CHECK:
  - On each cycle with mon_tvalid=1: sample_cnt++. If mon_tdata!=pattern, set err and exit to EVAL immediately.
  - On the beat where sample_cnt reaches CHECK_SAMPLES, go to EVAL.
  - to_cnt counts every CHECK cycle. When to_cnt reaches TIMEOUT_CYCLES without completing, set err and go to EVAL.
  - With mon_tvalid held high and no errors, CHECK lasts exactly CHECK_SAMPLES cycles.
- EVAL (1 cycle):
  - If !err: if cur_len==0 then cur_start=tap; then cur_len++. If the new cur_len > best_len (strictly greater, so the earliest window wins ties), best_len=cur_len and best_start=cur_start.
  - If err: cur_len=0.
  - If tap==MAX_TAP go to APPLY; else tap++ and go to LOAD.
  - cur_len/best_len are TAP_WIDTH+1 bits wide; no wrap is possible.
- APPLY (1 cycle):
  - If best_len>0: best_tap = best_start + ((best_len-1)>>1) (floor centre); pass=1.
  - Else: best_tap=0, pass=0.
  - In both cases eye_width=best_len, dly_tap<=best_tap, dly_load=1. Go to DONE.
- DONE (1 cycle): done=1, busy=0. Return to IDLE. Results hold until the next start.
- Clean-run latency (tvalid constant, all pass):
  - per tap = 1+SETTLE_CYCLES+CHECK_SAMPLES+1 = 322 cycles
  - start cycle N → done at N+1+32*322+1 = N+10306.
- dly_load total per run: 33 pulses (32 sweep loads plus the final apply).

Test Plan:
1. All taps pass (mon_tdata=pattern=32'hA5A5_5A5A, tvalid=1) → exactly 33 dly_load pulses; final dly_tap=15, best_tap=15, eye_width=32, pass=1; done 10306 cycles after start.
2. Bench corrupts mon_tdata unless current dly_tap is in 10..20 → eye_width=11, best_tap=15. Windows 2..5 and 20..27 → eye_width=8, best_tap=23. Tie windows 0..3 and 10..13 → best_tap=1.
3. Mismatch at every tap → pass=0, eye_width=0, final dly_load with dly_tap=0. Each tap exits CHECK after 1 beat (per-tap time 67 cycles).
4. mon_tvalid held low while dly_tap=7, otherwise clean → tap 7 times out after 4096 cycles and counts as fail; windows 0..6 and 8..31 → best_tap=19, eye_width=24.
5. mon_tvalid toggling 50% duty, all data matching → same results as scenario 1; CHECK lasts ~512 cycles per tap.
6. rst pulsed mid-CHECK at tap 12 → next cycle busy=0 and all outputs at reset values, no dly_load. start pulsed while busy → ignored. rst and start in the same cycle → stays IDLE.

Source files
------------

// File: rtl/adrv9001_rx_cal_if.sv
// RX calibration side-band bundle: the monitored capture stream (tvalid/tdata)
// plus the runtime delay-load port driven back into the capture block.
interface adrv9001_rx_cal_if #(
    parameter int TAP_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  mon_tvalid;
    logic [DATA_WIDTH-1:0] mon_tdata;
    logic [TAP_WIDTH-1:0]  dly_tap;
    logic                  dly_load;

    // Calibration sequencer: watches the stream, owns the delay-load port.
    modport master (
        input  mon_tvalid,
        input  mon_tdata,
        output dly_tap,
        output dly_load
    );

    // Capture block: sources the stream, latches dly_tap on dly_load.
    modport slave (
        output mon_tvalid,
        output mon_tdata,
        input  dly_tap,
        input  dly_load
    );
endinterface

// File: rtl/adrv9001_rx_cal.sv
// ADRV9001 RX LVDS delay calibration. Sweeps every input-delay tap, checks the
// captured stream against a static training pattern, then loads the centre of
// the longest contiguous run of passing taps (earliest run wins a tie).
module adrv9001_rx_cal #(
    parameter int TAP_WIDTH      = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int SETTLE_CYCLES  = 64,
    parameter int CHECK_SAMPLES  = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    adrv9001_rx_cal_if.master     rx,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [TAP_WIDTH-1:0]  best_tap,
    output logic [TAP_WIDTH:0]    eye_width
);
    localparam int LW = TAP_WIDTH + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(CHECK_SAMPLES + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TAP_WIDTH-1:0] MAX_TAP     = '1;
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]        SAMPLE_LAST = CW'(CHECK_SAMPLES - 1);
    localparam logic [OW-1:0]        TO_LAST     = OW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_APPLY, S_DONE
    } state_t;

    state_t               state;
    logic [TAP_WIDTH-1:0] tap;
    logic [TAP_WIDTH-1:0] cur_start;
    logic [TAP_WIDTH-1:0] best_start;
    logic [LW-1:0]        cur_len;
    logic [LW-1:0]        best_len;
    logic [SW-1:0]        settle_cnt;
    logic [CW-1:0]        sample_cnt;
    logic [OW-1:0]        to_cnt;
    logic                 err;

    logic [LW-1:0]        next_len;
    logic [LW-1:0]        half_len;
    logic [TAP_WIDTH-1:0] run_start;
    logic [TAP_WIDTH-1:0] centre;
    logic                 beat_bad;

    // Run bookkeeping: extended run length, its start tap, and floor centre of the best run.
    assign next_len  = cur_len + LW'(1);
    assign run_start = (cur_len == '0) ? tap : cur_start;
    assign half_len  = (best_len - LW'(1)) >> 1;
    assign centre    = TAP_WIDTH'(LW'(best_start) + half_len);
    assign beat_bad  = rx.mon_tvalid && (rx.mon_tdata != pattern);

    // Sequencer FSM with registered outputs; dly_load and done are single-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tap         <= '0;
            cur_start   <= '0;
            best_start  <= '0;
            cur_len     <= '0;
            best_len    <= '0;
            settle_cnt  <= '0;
            sample_cnt  <= '0;
            to_cnt      <= '0;
            err         <= 1'b0;
            rx.dly_tap  <= '0;
            rx.dly_load <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            best_tap    <= '0;
            eye_width   <= '0;
        end else begin
            rx.dly_load <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tap        <= '0;
                        cur_start  <= '0;
                        best_start <= '0;
                        cur_len    <= '0;
                        best_len   <= '0;
                        pass       <= 1'b0;
                        best_tap   <= '0;
                        eye_width  <= '0;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rx.dly_tap  <= tap;
                    rx.dly_load <= 1'b1;
                    settle_cnt  <= '0;
                    state       <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Data is discarded while the delay line settles.
                    if (settle_cnt == SETTLE_LAST) begin
                        sample_cnt <= '0;
                        to_cnt     <= '0;
                        err        <= 1'b0;
                        state      <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_CHECK: begin
                    to_cnt <= to_cnt + OW'(1);
                    if (rx.mon_tvalid)
                        sample_cnt <= sample_cnt + CW'(1);
                    // A completing beat takes priority over a coincident timeout.
                    if (beat_bad) begin
                        err   <= 1'b1;
                        state <= S_EVAL;
                    end else if (rx.mon_tvalid && sample_cnt == SAMPLE_LAST) begin
                        state <= S_EVAL;
                    end else if (to_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (!err) begin
                        cur_len   <= next_len;
                        cur_start <= run_start;
                        if (next_len > best_len) begin
                            best_len   <= next_len;
                            best_start <= run_start;
                        end
                    end else begin
                        cur_len <= '0;
                    end
                    if (tap == MAX_TAP) begin
                        state <= S_APPLY;
                    end else begin
                        tap   <= tap + TAP_WIDTH'(1);
                        state <= S_LOAD;
                    end
                end
                S_APPLY: begin
                    eye_width   <= best_len;
                    rx.dly_load <= 1'b1;
                    if (best_len != '0) begin
                        best_tap   <= centre;
                        rx.dly_tap <= centre;
                        pass       <= 1'b1;
                    end else begin
                        best_tap   <= '0;
                        rx.dly_tap <= '0;
                        pass       <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adrv9001_rx_cal.sv
// Scoreboard bench for adrv9001_rx_cal: each sweep pushes its expected outcome,
// the run is driven to done, and the popped expectation is compared.
module tb_adrv9001_rx_cal;
    localparam int          TW  = 5;
    localparam int          DW  = 32;
    localparam logic [31:0] PAT = 32'hA5A5_5A5A;
    localparam int          BOUND = 30000;

    typedef struct packed {
        logic          pass;
        logic [TW-1:0] best;
        logic [TW:0]   eye;
        logic [TW-1:0] last_load;
        logic [TW-1:0] dly;
        logic          busy1;
    } res_t;

    typedef struct {
        res_t res;
        int   loads;
        int   lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [TW-1:0] best_tap;
    logic [TW:0]   eye_width;

    logic [31:0] good_mask = '1;
    int          tv_mode = 0;
    logic        tog = 1'b0;

    int   checks = 0;
    int   passed = 0;
    exp_t exp_q[$];

    adrv9001_rx_cal_if #(.TAP_WIDTH(TW), .DATA_WIDTH(DW)) rx_if();

    // Capture-block model: corrupt data on taps outside good_mask; tvalid per mode.
    assign rx_if.mon_tdata  = good_mask[rx_if.dly_tap] ? PAT : ~PAT;
    assign rx_if.mon_tvalid = (tv_mode == 0) ? 1'b1 :
                              (tv_mode == 1) ? tog  : (rx_if.dly_tap != 5'd7);

    adrv9001_rx_cal dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (PAT),
        .rx        (rx_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .best_tap  (best_tap),
        .eye_width (eye_width)
    );

    always #5 clk = ~clk;
    always @(negedge clk) tog = ~tog;

    // Drive one calibration and collect what the DUT reports; optional stray start at lat==poke.
    task automatic run_cal(input int poke, output res_t r, output int loads,
                           output int lat, output bit timed_out);
        r = '0; loads = 0; lat = 0; timed_out = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        r.busy1 = busy;
        while (!done && lat < BOUND) begin
            @(negedge clk);
            lat++;
            start = (lat == poke);
            if (dly_load_seen()) begin
                loads++;
                r.last_load = rx_if.dly_tap;
            end
        end
        start = 1'b0;
        timed_out = !done;
        r.pass = pass;
        r.best = best_tap;
        r.eye  = eye_width;
        r.dly  = rx_if.dly_tap;
        @(negedge clk);
    endtask

    function automatic bit dly_load_seen();
        return rx_if.dly_load === 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_if.dly_tap, rx_if.dly_load, busy, done} !== '0)
            $display("FAIL reset_ctrl: dly_tap=%0d dly_load=%b busy=%b done=%b, want all 0",
                     rx_if.dly_tap, rx_if.dly_load, busy, done);
        else passed++;
        checks++;
        if ({pass, best_tap, eye_width} !== '0)
            $display("FAIL reset_results: pass=%b best_tap=%0d eye_width=%0d, want 0",
                     pass, best_tap, eye_width);
        else passed++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, rx_if.dly_load} !== 2'b00)
            $display("FAIL idle_no_start: busy=%b dly_load=%b, want 0 0", busy, rx_if.dly_load);
        else passed++;
    endtask

    task automatic test_all_pass();
        exp_t e; res_t r; int loads, lat; bit to;
        good_mask = '1; tv_mode = 0;
        exp_q.push_back('{res: '{1'b1, 5'd15, 6'd32, 5'd15, 5'd15, 1'b1}, loads: 33, lat: 10306});
        run_cal(-1, r, loads, lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e.res)
            $display("FAIL all_pass_result: timeout=%b got %h want %h", to, r, e.res);
        else passed++;
        checks++;
        if (loads != e.loads || lat != e.lat)
            $display("FAIL all_pass_timing: loads=%0d lat=%0d want loads=%0d lat=%0d",
                     loads, lat, e.loads, e.lat);
        else passed++;
    endtask

    task automatic test_windows();
        logic [31:0] masks[3] = '{32'h001F_FC00, 32'h0FF0_003C, 32'h0000_3C0F};
        logic [4:0]  bests[3] = '{5'd15, 5'd23, 5'd1};
        logic [5:0]  eyes[3]  = '{6'd11, 6'd8, 6'd4};
        int          lats[3]  = '{4951, 5206, 4186};
        exp_t e; res_t r; int loads, lat; bit to;
        tv_mode = 0;
        for (int i = 0; i < 3; i++) begin
            good_mask = masks[i];
            exp_q.push_back('{res: '{1'b1, bests[i], eyes[i], bests[i], bests[i], 1'b1},
                              loads: 33, lat: lats[i]});
            // Second window run also carries a start pulse mid-sweep that must be ignored.
            run_cal((i == 1) ? 1000 : -1, r, loads, lat, to);
            e = exp_q.pop_front();
            checks++;
            if (to || r !== e.res)
                $display("FAIL window%0d_result: timeout=%b got %h want %h", i, to, r, e.res);
            else passed++;
            checks++;
            if (loads != e.loads || lat != e.lat)
                $display("FAIL window%0d_timing: loads=%0d lat=%0d want loads=%0d lat=%0d",
                         i, loads, lat, e.loads, e.lat);
            else passed++;
        end
    endtask

    task automatic test_all_fail();
        exp_t e; res_t r; int loads, lat; bit to;
        good_mask = '0; tv_mode = 0;
        exp_q.push_back('{res: '{1'b0, 5'd0, 6'd0, 5'd0, 5'd0, 1'b1}, loads: 33, lat: 2146});
        run_cal(-1, r, loads, lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e.res)
            $display("FAIL all_fail_result: timeout=%b got %h want %h", to, r, e.res);
        else passed++;
        checks++;
        if (loads != e.loads || lat != e.lat)
            $display("FAIL all_fail_timing: loads=%0d lat=%0d want loads=%0d lat=%0d",
                     loads, lat, e.loads, e.lat);
        else passed++;
    endtask

    task automatic test_timeout();
        exp_t e; res_t r; int loads, lat; bit to;
        good_mask = '1; tv_mode = 2;
        exp_q.push_back('{res: '{1'b1, 5'd19, 6'd24, 5'd19, 5'd19, 1'b1}, loads: 33, lat: 14146});
        run_cal(-1, r, loads, lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e.res)
            $display("FAIL timeout_result: timeout=%b got %h want %h", to, r, e.res);
        else passed++;
        checks++;
        if (loads != e.loads || lat != e.lat)
            $display("FAIL timeout_timing: loads=%0d lat=%0d want loads=%0d lat=%0d",
                     loads, lat, e.loads, e.lat);
        else passed++;
    endtask

    task automatic test_toggle();
        exp_t e; res_t r; int loads, lat; bit to;
        good_mask = '1; tv_mode = 1;
        exp_q.push_back('{res: '{1'b1, 5'd15, 6'd32, 5'd15, 5'd15, 1'b1}, loads: 33, lat: 0});
        run_cal(-1, r, loads, lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e.res)
            $display("FAIL toggle_result: timeout=%b got %h want %h", to, r, e.res);
        else passed++;
        // 256 beats at half rate take 511 or 512 CHECK cycles per tap.
        checks++;
        if (loads != e.loads || lat < 2 + 32 * 577 || lat > 2 + 32 * 578)
            $display("FAIL toggle_timing: loads=%0d lat=%0d want loads=%0d lat %0d..%0d",
                     loads, lat, e.loads, 2 + 32 * 577, 2 + 32 * 578);
        else passed++;
        tv_mode = 0;
    endtask

    task automatic test_rst_abort();
        int loads = 0;
        int n = 0;
        int stray = 0;
        good_mask = '1; tv_mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (loads < 13 && n < BOUND) begin
            @(negedge clk);
            n++;
            if (dly_load_seen()) loads++;
        end
        checks++;
        if (loads != 13 || rx_if.dly_tap !== 5'd12)
            $display("FAIL abort_reach_tap12: loads=%0d dly_tap=%0d want 13 and 12",
                     loads, rx_if.dly_tap);
        else passed++;
        repeat (84) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rx_if.dly_load, done, pass, rx_if.dly_tap, best_tap, eye_width} !== '0)
            $display("FAIL abort_reset_vals: busy=%b load=%b done=%b pass=%b tap=%0d best=%0d eye=%0d want 0",
                     busy, rx_if.dly_load, done, pass, rx_if.dly_tap, best_tap, eye_width);
        else passed++;
        rst = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (dly_load_seen() || busy || done) stray++;
        end
        checks++;
        if (stray != 0)
            $display("FAIL abort_quiet: %0d active cycles after reset, want 0", stray);
        else passed++;
    endtask

    task automatic test_rst_start();
        int stray = 0;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dly_load_seen() || busy) stray++;
        end
        checks++;
        if (stray != 0)
            $display("FAIL rst_over_start: %0d active cycles, want 0", stray);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_windows();
        test_all_fail();
        test_timeout();
        test_toggle();
        test_rst_abort();
        test_rst_start();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
